alu_sequencer: RTL and testbench
================================

# alu_sequencer

Micro-sequencer that owns the register-file/ALU datapath and executes a queue of register-to-register instructions on it. Instructions arrive over a valid/ready port into an internal FIFO. The block drives the datapath's read selects, write-back controls, opcode and shift amount, and returns each instruction's result over a valid/ready response port. It sits between the instruction source (bench or host) and the existing `project` datapath, replacing hand-driven control.

## Interface
- `DEPTH`, 4: instruction FIFO entries; power of two, minimum 2.
- `clk`  in  1  rising-edge clock.
- `rstN`  in  1  asynchronous active-low reset.
- `inValid`  in  1  instruction offered.
- `inReady`  out  1  FIFO can accept; equals !full. No same-cycle pass-through when full.
- `inKind`  in  1  0 = ALU op, 1 = load immediate.
- `inOp`  in  4  ALU opcode; valid 0–8, 9–15 illegal.
- `inRd`, `inRs1`, `inRs2`  in  5 each  destination and source register indices.
- `inShamt`  in  5  shift amount.
- `inImm`  in  32  immediate; used only when `inKind`=1.
- `wrEnable`, `wrReg[4:0]`, `rdReg1[4:0]`, `rdReg2[4:0]`, `opCode[3:0]`, `shiftAmt[4:0]`, `selCh`, `selData[31:0]`  out  datapath controls. All are registered. `selCh`=1 writes the ALU result; `selCh`=0 writes `selData`.
- `result`  in  32 signed  ALU output from the datapath (combinational).
- `rspValid`  out  1  response available.
- `rspReady`  in  1  response consumed.
- `rspData`  out  32  written value (ALU result or immediate); 0 on error.
- `rspErr`  out  1  illegal opcode; no write-back performed.
- `rspFlags`  out  2  {negative, zero} of `rspData`. Present only with `ALU_SEQ_FLAG_EN`.

## Operation
- FIFO holds {kind, op, rd, rs1, rs2, shamt, imm}. Push on `inValid & inReady`. Pop only in IDLE.
- FSM states: IDLE, EXEC, WRITE, RESP.
  - **IDLE:** if the FIFO is non-empty, pop and load the output registers, then go to EXEC. Loaded values: `rdReg1`=rs1, `rdReg2`=rs2, `opCode`=op, `shiftAmt`=shamt, `wrReg`=rd, `selCh`=!kind, `selData`=imm (0 when kind=0). If the FIFO is empty, stay in IDLE.
  - **EXEC:** one cycle with `wrEnable`=0 so the ALU output settles. Go to WRITE.
  - **WRITE:** one cycle.
    - Legal instruction: `wrEnable`=1. At the closing edge, capture `rspData` (`result` if kind=0, imm if kind=1) with `rspErr`=0.
    - kind=0 with op>8: `wrEnable` stays 0; capture `rspData`=0, `rspErr`=1.
    - Go to RESP.
  - **RESP:** `rspValid`=1, and all `rsp*` outputs are held stable. On `rspValid & rspReady`, go to IDLE.
- `wrEnable` is high only in WRITE and never for two consecutive cycles.
- Datapath controls other than `wrEnable` hold their last values outside IDLE→EXEC loads.
- Instructions complete strictly in order. Each instruction's write lands before the next instruction's read, so there are no hazards.
- Reset values: `inReady`=1, `rspValid`=0, `rspData`=0, `rspErr`=0, `rspFlags`=0, `wrEnable`=0, `selCh`=0, and all other datapath outputs 0. FSM returns to IDLE and the FIFO is emptied.
- Reset asserted mid-instruction: `wrEnable` drops asynchronously, the in-flight instruction and queued entries are discarded, and no response is produced.

## Timing
- Instruction accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - pop at E1;
  - EXEC E1–E2;
  - WRITE E2–E3 (register file writes at E3);
  - `rspValid` high from E3.
- Latency from acceptance to `rspValid` is 3 cycles.
- Throughput with `rspReady` held at 1: one instruction per 4 cycles (IDLE, EXEC, WRITE, RESP).
- Backpressure: while `rspReady`=0 the FSM stays in RESP. The FIFO keeps accepting until full, then `inReady`=0.
- Push and pop in the same cycle: occupancy is unchanged. Pointers wrap modulo `DEPTH`.

## Configuration
- `ALU_SEQ_FLAG_EN` defined: the `rspFlags` port exists. zero = (`rspData`==0), negative = `rspData`[31]. Flags are captured with `rspData`.
- `ALU_SEQ_FLAG_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Load imm 1→r0, imm 7→r1, then ADD rd=r2, rs1=r0, rs2=r1 → responses 1, 7, 8 with `rspErr`=0. `wrEnable` pulses exactly once per instruction, with `wrReg`=0, 1, 2.
- SUB r0−r1 → `rspData`=−6. With flags enabled, negative=1 and zero=0.
- SLL by 3 of r0=1 into r0, then SRA by 1 of r0 → responses 8, then 4.
- Opcode 12 → `rspErr`=1, `rspData`=0, and `wrEnable` never rises; a subsequent readback of the destination register is unchanged.
- Push 6 instructions with `rspReady`=0 and `DEPTH`=4 → `inReady` falls after 4 accepted entries plus the one in flight. Releasing `rspReady` drains all responses in order.
- Assert `rstN`=0 during WRITE → `wrEnable` and `rspValid` go to 0 immediately, the FIFO is empty, and after release `inReady`=1 with no stale response.

Source files
------------

// File: rtl/alu_sequencer.sv
// Micro-sequencer driving the register-file/ALU datapath from a queue of instructions.
// Optional `ALU_SEQ_FLAG_EN` adds the rspFlags {negative, zero} response port.
module alu_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic               inKind,
  input  logic [3:0]         inOp,
  input  logic [4:0]         inRd,
  input  logic [4:0]         inRs1,
  input  logic [4:0]         inRs2,
  input  logic [4:0]         inShamt,
  input  logic [31:0]        inImm,
  output logic               wrEnable,
  output logic [4:0]         wrReg,
  output logic [4:0]         rdReg1,
  output logic [4:0]         rdReg2,
  output logic [3:0]         opCode,
  output logic [4:0]         shiftAmt,
  output logic               selCh,
  output logic [31:0]        selData,
  input  logic signed [31:0] result,
  output logic               rspValid,
  input  logic               rspReady,
  output logic [1:0]         dbgState,
  output logic [31:0]        rspData,
  output logic               rspErr
`ifdef ALU_SEQ_FLAG_EN
  ,
  output logic [1:0]         rspFlags
`endif
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and the rsp* outputs are held stable while rspValid is high.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef struct packed {
    logic        kind;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic [31:0] imm;
  } instrT;

  instrT       mem [DEPTH];
  instrT       inEntry;
  instrT       head;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic          push;
  logic          pop;
  logic          illegalOp;
  logic [31:0]   wbData;

  assign inEntry  = '{kind: inKind, op: inOp, rd: inRd, rs1: inRs1, rs2: inRs2,
                      shamt: inShamt, imm: inImm};
  assign head     = mem[rdPtr];
  assign inReady  = (count != FULL_COUNT);
  assign push     = inValid && inReady;
  assign pop      = (state == IDLE) && (count != '0);
  assign rspValid = (state == RESP);
  assign dbgState = state;

  // Only ALU ops can be illegal; a load immediate ignores its opcode field.
  assign illegalOp = selCh && (opCode > 4'd8);

  always_comb begin
    wbData = '0;
    if (!illegalOp) wbData = selCh ? result : selData;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inEntry;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      wrEnable <= 1'b0;
      wrReg    <= '0;
      rdReg1   <= '0;
      rdReg2   <= '0;
      opCode   <= '0;
      shiftAmt <= '0;
      selCh    <= 1'b0;
      selData  <= '0;
      rspData  <= '0;
      rspErr   <= 1'b0;
    end else begin
      // High for exactly the WRITE cycle of a legal instruction.
      wrEnable <= (state == EXEC) && !illegalOp;
      case (state)
        IDLE: begin
          if (pop) begin
            rdReg1   <= head.rs1;
            rdReg2   <= head.rs2;
            opCode   <= head.op;
            shiftAmt <= head.shamt;
            wrReg    <= head.rd;
            selCh    <= !head.kind;
            selData  <= head.kind ? head.imm : 32'd0;
            state    <= EXEC;
          end
        end
        EXEC:  state <= WRITE;
        WRITE: begin
          rspData <= wbData;
          rspErr  <= illegalOp;
          state   <= RESP;
        end
        RESP: begin
          if (rspReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAG_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rspFlags <= 2'b00;
    else if (state == WRITE) rspFlags <= {wbData[31], wbData == 32'd0};
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file + ALU model.
// Build with +define+ALU_SEQ_FLAG_EN to also check rspFlags.
module tb_alu_sequencer;
  logic               clk = 1'b0;
  logic               rstN;
  logic               inValid;
  logic               inReady;
  logic               inKind;
  logic [3:0]         inOp;
  logic [4:0]         inRd;
  logic [4:0]         inRs1;
  logic [4:0]         inRs2;
  logic [4:0]         inShamt;
  logic [31:0]        inImm;
  logic               wrEnable;
  logic [4:0]         wrReg;
  logic [4:0]         rdReg1;
  logic [4:0]         rdReg2;
  logic [3:0]         opCode;
  logic [4:0]         shiftAmt;
  logic               selCh;
  logic [31:0]        selData;
  logic signed [31:0] result;
  logic               rspValid;
  logic               rspReady;
  logic [1:0]         dbgState;
  logic [31:0]        rspData;
  logic               rspErr;
`ifdef ALU_SEQ_FLAG_EN
  logic [1:0]         rspFlags;
`endif

  int nChecks = 0;
  int nPass = 0;
  int nAccepted = 0;
  int cyc = 0;
  int wePulses = 0;
  int weDouble = 0;
  logic prevWe = 1'b0;
  logic [4:0] weRegs[$];
  logic [31:0] exp_q[$];
  logic [31:0] rf [32];

  logic [31:0] gotData;
  logic        gotErr;
  logic [1:0]  gotFlags;
  int          gotCyc;

  alu_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .inKind(inKind), .inOp(inOp),
    .inRd(inRd), .inRs1(inRs1), .inRs2(inRs2), .inShamt(inShamt), .inImm(inImm),
    .wrEnable(wrEnable), .wrReg(wrReg), .rdReg1(rdReg1), .rdReg2(rdReg2),
    .opCode(opCode), .shiftAmt(shiftAmt), .selCh(selCh), .selData(selData),
    .result(result), .rspValid(rspValid), .rspReady(rspReady),
    .dbgState(dbgState), .rspData(rspData), .rspErr(rspErr)
`ifdef ALU_SEQ_FLAG_EN
    , .rspFlags(rspFlags)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- datapath model ----------------
  // Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT.
  function automatic logic signed [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [3:0] op, input logic [4:0] sh);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign result = aluModel(rf[rdReg1], rf[rdReg2], opCode, shiftAmt);

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  end

  always @(posedge clk) begin
    cyc++;
    if (wrEnable) begin
      wePulses++;
      weRegs.push_back(wrReg);
      rf[wrReg] <= selCh ? result : selData;
    end
    if (wrEnable && prevWe) weDouble++;
    prevWe = wrEnable;
  end

  // ---------------- driver tasks ----------------
  task automatic pushInstr(input logic kind, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] shamt, input logic [31:0] imm);
    int waitCyc = 0;
    inValid = 1'b1; inKind = kind; inOp = op; inRd = rd;
    inRs1 = rs1; inRs2 = rs2; inShamt = shamt; inImm = imm;
    while (!inReady && waitCyc < 200) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (!inReady) begin
      nChecks++;
      $display("FAIL push_timeout: inReady got %0b required 1", inReady);
    end else begin
      @(posedge clk); #1;
      nAccepted++;
    end
    inValid = 1'b0;
  endtask

  // Waits for a response, records it, then lets the handshake edge pass (rspReady held by caller).
  task automatic collect();
    int waitCyc = 0;
    while (!rspValid && waitCyc < 200) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (!rspValid) begin
      nChecks++;
      $display("FAIL rsp_timeout: rspValid got %0b required 1", rspValid);
    end
    gotData = rspData;
    gotErr = rspErr;
`ifdef ALU_SEQ_FLAG_EN
    gotFlags = rspFlags;
`else
    gotFlags = 2'b00;
`endif
    gotCyc = cyc;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nChecks++;
    if (inReady !== 1'b1 || rspValid !== 1'b0) $display("FAIL reset_hs: inReady/rspValid got %0b%0b required 10", inReady, rspValid);
    else nPass++;
    nChecks++;
    if (rspData !== 32'd0 || rspErr !== 1'b0) $display("FAIL reset_rsp: rspData/rspErr got %0h/%0b required 0/0", rspData, rspErr);
    else nPass++;
    nChecks++;
    if (wrEnable !== 1'b0 || selCh !== 1'b0) $display("FAIL reset_we: wrEnable/selCh got %0b%0b required 00", wrEnable, selCh);
    else nPass++;
    nChecks++;
    if ({wrReg, rdReg1, rdReg2, opCode, shiftAmt, selData} !== '0)
      $display("FAIL reset_ctrl: controls got %0h required 0", {wrReg, rdReg1, rdReg2, opCode, shiftAmt, selData});
    else nPass++;
`ifdef ALU_SEQ_FLAG_EN
    nChecks++;
    if (rspFlags !== 2'b00) $display("FAIL reset_flags: got %0b required 00", rspFlags);
    else nPass++;
`endif
    rstN = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if (dbgState !== 2'd0) $display("FAIL reset_state: got %0d required 0", dbgState);
    else nPass++;
  endtask

  task automatic test_load_add();
    int lat = 0;
    rspReady = 1'b1;
    weRegs.delete();
    wePulses = 0;
    pushInstr(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd1);
    while (!rspValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    nChecks++;
    if (lat != 3) $display("FAIL latency: got %0d required 3", lat);
    else nPass++;
    nChecks++;
    if (rspData !== 32'd1 || rspErr !== 1'b0) $display("FAIL ldi1: got %0h/%0b required 1/0", rspData, rspErr);
    else nPass++;
    pushInstr(1'b1, 4'd0, 5'd1, 5'd0, 5'd0, 5'd0, 32'd7);
    pushInstr(1'b0, 4'd0, 5'd2, 5'd0, 5'd1, 5'd0, 32'd0);
    collect();
    nChecks++;
    if (gotData !== 32'd7 || gotErr !== 1'b0) $display("FAIL ldi7: got %0h/%0b required 7/0", gotData, gotErr);
    else nPass++;
    collect();
    nChecks++;
    if (gotData !== 32'd8 || gotErr !== 1'b0) $display("FAIL add: got %0h/%0b required 8/0", gotData, gotErr);
    else nPass++;
    nChecks++;
    if (wePulses != 3) $display("FAIL we_count: got %0d required 3", wePulses);
    else nPass++;
    nChecks++;
    if (weRegs.size() != 3) $display("FAIL we_regs: got %0d writes required 3", weRegs.size());
    else if ({weRegs[0], weRegs[1], weRegs[2]} !== {5'd0, 5'd1, 5'd2})
      $display("FAIL we_regs: got %0d,%0d,%0d required 0,1,2", weRegs[0], weRegs[1], weRegs[2]);
    else nPass++;
  endtask

  task automatic test_sub_flags();
    pushInstr(1'b0, 4'd1, 5'd3, 5'd0, 5'd1, 5'd0, 32'd0);
    collect();
    nChecks++;
    if (gotData !== 32'hFFFF_FFFA || gotErr !== 1'b0) $display("FAIL sub: got %0h/%0b required fffffffa/0", gotData, gotErr);
    else nPass++;
`ifdef ALU_SEQ_FLAG_EN
    nChecks++;
    if (gotFlags !== 2'b10) $display("FAIL sub_flags: got %0b required 10", gotFlags);
    else nPass++;
`endif
  endtask

  task automatic test_shift();
    pushInstr(1'b0, 4'd5, 5'd0, 5'd0, 5'd0, 5'd3, 32'd0);
    pushInstr(1'b0, 4'd7, 5'd0, 5'd0, 5'd0, 5'd1, 32'd0);
    collect();
    nChecks++;
    if (gotData !== 32'd8) $display("FAIL sll: got %0h required 8", gotData);
    else nPass++;
    collect();
    nChecks++;
    if (gotData !== 32'd4) $display("FAIL sra: got %0h required 4", gotData);
    else nPass++;
  endtask

  task automatic test_illegal();
    int pulses0 = wePulses;
    pushInstr(1'b0, 4'd12, 5'd3, 5'd0, 5'd1, 5'd0, 32'd0);
    collect();
    nChecks++;
    if (gotData !== 32'd0 || gotErr !== 1'b1) $display("FAIL illegal: got %0h/%0b required 0/1", gotData, gotErr);
    else nPass++;
    nChecks++;
    if (wePulses != pulses0) $display("FAIL illegal_we: got %0d pulses required 0", wePulses - pulses0);
    else nPass++;
`ifdef ALU_SEQ_FLAG_EN
    nChecks++;
    if (gotFlags !== 2'b01) $display("FAIL illegal_flags: got %0b required 01", gotFlags);
    else nPass++;
`endif
    pushInstr(1'b0, 4'd3, 5'd4, 5'd3, 5'd3, 5'd0, 32'd0);
    collect();
    nChecks++;
    if (gotData !== 32'hFFFF_FFFA) $display("FAIL illegal_readback: got %0h required fffffffa", gotData);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    int base = nAccepted;
    int badGap = 0;
    int lastCyc = 0;
    rspReady = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] imm;
          imm = 32'h100 + 32'h11 * i;
          exp_q.push_back(imm);
          pushInstr(1'b1, 4'd0, 5'(8 + i), 5'd0, 5'd0, 5'd0, imm);
        end
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        nChecks++;
        if (inReady !== 1'b0) $display("FAIL full_ready: got %0b required 0", inReady);
        else nPass++;
        nChecks++;
        if (nAccepted - base != 5) $display("FAIL full_count: got %0d accepted required 5", nAccepted - base);
        else nPass++;
        nChecks++;
        if (rspValid !== 1'b1 || rspData !== 32'h100) $display("FAIL held_rsp: got %0b/%0h required 1/100", rspValid, rspData);
        else nPass++;
        rspReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
          logic [31:0] expv;
          collect();
          expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          nChecks++;
          if (gotData !== expv) $display("FAIL drain%0d: got %0h required %0h", i, gotData, expv);
          else nPass++;
          if (i > 0 && gotCyc - lastCyc != 4) badGap++;
          lastCyc = gotCyc;
        end
        nChecks++;
        if (badGap != 0) $display("FAIL throughput: got %0d gaps not 4 cycles required 0", badGap);
        else nPass++;
      end
    join
  endtask

  task automatic test_reset_mid();
    int pulses0;
    int waitCyc = 0;
    int sawValid = 0;
    rspReady = 1'b1;
    pushInstr(1'b1, 4'd0, 5'd5, 5'd0, 5'd0, 5'd0, 32'hDEAD);
    pushInstr(1'b1, 4'd0, 5'd6, 5'd0, 5'd0, 5'd0, 32'hBEEF);
    while (!wrEnable && waitCyc < 20) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    nChecks++;
    if (wrEnable !== 1'b1) $display("FAIL rst_mid_write: wrEnable got %0b required 1", wrEnable);
    else nPass++;
    pulses0 = wePulses;
    rstN = 1'b0;
    #1;
    nChecks++;
    if (wrEnable !== 1'b0 || rspValid !== 1'b0) $display("FAIL rst_mid_async: wrEnable/rspValid got %0b%0b required 00", wrEnable, rspValid);
    else nPass++;
    nChecks++;
    if (inReady !== 1'b1 || dbgState !== 2'd0) $display("FAIL rst_mid_empty: inReady/state got %0b/%0d required 1/0", inReady, dbgState);
    else nPass++;
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rspValid) sawValid++;
    end
    nChecks++;
    if (sawValid != 0 || wePulses != pulses0) $display("FAIL rst_mid_stale: rspValid cycles %0d writes %0d required 0/0", sawValid, wePulses - pulses0);
    else nPass++;
    nChecks++;
    if (rf[5] !== 32'd0 || rf[6] !== 32'd0) $display("FAIL rst_mid_rf: got %0h/%0h required 0/0", rf[5], rf[6]);
    else nPass++;
    nChecks++;
    if (weDouble != 0) $display("FAIL we_double: got %0d back-to-back writes required 0", weDouble);
    else nPass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rstN = 1'b0;
    inValid = 1'b0; inKind = 1'b0; inOp = '0; inRd = '0;
    inRs1 = '0; inRs2 = '0; inShamt = '0; inImm = '0;
    rspReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_load_add();
    test_sub_flags();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
